// File: rtl/cal_fifo_pkg.sv
// rtl/cal_fifo_pkg.sv - shared constants and helpers for calibrator FIFOs
package cal_fifo_pkg;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v = value - 1;
        while (v > 0) begin
            res = res + 1;
            v = v >> 1;
        end
        return res;
    endfunction

    localparam int CAL_FIFO_WIDTH      = 32;
    localparam int CAL_FIFO_DEPTH      = 128;
    localparam int CAL_FIFO_DEPTH_LOG2 = clog2(CAL_FIFO_DEPTH);
    localparam int CAL_FIFO_PIPE_MAX   = 1;

endpackage

// File: rtl/cal_sdp_ram.sv
// rtl/cal_sdp_ram.sv - simple dual-port RAM, registered read, optional output register
module cal_sdp_ram
    import cal_fifo_pkg::*;
#(
    parameter int WIDTH      = CAL_FIFO_WIDTH,
    parameter int DEPTH_LOG2 = CAL_FIFO_DEPTH_LOG2,
    parameter int PIPE       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    input  logic                  oe,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register only loads on an accepted read so downstream data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else if (re) begin
            rd_q <= mem[raddr];
        end
    end

    generate
        if (PIPE != 0) begin : g_out_reg
            logic [WIDTH-1:0] out_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                end else if (oe) begin
                    out_q <= rd_q;
                end
            end
            assign rdata = out_q;
        end else begin : g_no_out_reg
            logic unused_oe;
            assign unused_oe = oe;
            assign rdata     = rd_q;
        end
    endgenerate

endmodule

// File: rtl/cal_sync_fifo.sv
// rtl/cal_sync_fifo.sv - single-clock calibrator FIFO with registered flags, count and error pulses
module cal_sync_fifo
    import cal_fifo_pkg::*;
#(
    parameter int WIDTH      = CAL_FIFO_WIDTH,
    parameter int DEPTH_LOG2 = CAL_FIFO_DEPTH_LOG2,
    parameter int PIPE       = 1,
    parameter int AFULL_TH   = 120,
    parameter int AEMPTY_TH  = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  CLEAR,
    input  logic [WIDTH-1:0]      WDATA,
    input  logic                  WE,
    input  logic                  RE,
    output logic [WIDTH-1:0]      RDATA,
    output logic                  RVALID,
    output logic                  FULL,
    output logic                  AFULL,
    output logic                  EMPTY,
    output logic                  AEMPTY,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AFULL_C  = (DEPTH_LOG2+1)'(AFULL_TH);
    localparam logic [DEPTH_LOG2:0] AEMPTY_C = (DEPTH_LOG2+1)'(AEMPTY_TH);

    generate
        if (AEMPTY_TH < 0 || AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH) begin : g_bad_thresholds
            $error("cal_sync_fifo: thresholds must satisfy 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
        end
        if (PIPE < 0 || PIPE > CAL_FIFO_PIPE_MAX) begin : g_bad_pipe
            $error("cal_sync_fifo: PIPE out of range");
        end
        if (WIDTH < 1 || WIDTH > 64 || DEPTH_LOG2 < 1 || DEPTH_LOG2 > 12) begin : g_bad_size
            $error("cal_sync_fifo: WIDTH or DEPTH_LOG2 out of range");
        end
    endgenerate

    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rd_v1;

    // Decisions use the registered flags; CLEAR suppresses both ports.
    assign wr_acc = WE && !FULL && !CLEAR;
    assign rd_acc = RE && !EMPTY && !CLEAR;

    always_comb begin
        count_nxt = COUNT;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = COUNT + (DEPTH_LOG2+1)'(1);
            2'b01:   count_nxt = COUNT - (DEPTH_LOG2+1)'(1);
            default: count_nxt = COUNT;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wptr      <= '0;
            rptr      <= '0;
            COUNT     <= '0;
            FULL      <= 1'b0;
            AFULL     <= 1'b0;
            EMPTY     <= 1'b1;
            AEMPTY    <= 1'b1;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
            rd_v1     <= 1'b0;
            RVALID    <= 1'b0;
        end else if (CLEAR) begin
            wptr      <= '0;
            rptr      <= '0;
            COUNT     <= '0;
            FULL      <= 1'b0;
            AFULL     <= 1'b0;
            EMPTY     <= 1'b1;
            AEMPTY    <= 1'b1;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
            rd_v1     <= 1'b0;
            RVALID    <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + DEPTH_LOG2'(1);
            if (rd_acc) rptr <= rptr + DEPTH_LOG2'(1);
            COUNT     <= count_nxt;
            FULL      <= (count_nxt == DEPTH_C);
            AFULL     <= (count_nxt >= AFULL_C);
            EMPTY     <= (count_nxt == '0);
            AEMPTY    <= (count_nxt <= AEMPTY_C);
            OVERFLOW  <= WE && FULL;
            UNDERFLOW <= RE && EMPTY;
            rd_v1     <= rd_acc;
            RVALID    <= (PIPE == 0) ? rd_acc : rd_v1;
        end
    end

    // Output register only advances for reads that survive a flush, so RDATA holds on squash.
    cal_sdp_ram #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .PIPE       (PIPE)
    ) u_ram (
        .clk   (CLOCK),
        .rst   (RESET),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (WDATA),
        .re    (rd_acc),
        .raddr (rptr),
        .oe    (rd_v1 && !CLEAR),
        .rdata (RDATA)
    );

endmodule
